// File: rtl/instr_encoder_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_if
// Request/response bundle for the MIPS instruction encoder.
//   master : request side (drives clear, request fields, out_ready)
//   slave  : encoder side (drives in_ready, out_valid, out_instr, count,
//            err_illegal)
// Signals:
//   clear       synchronous flush of queue and error flag
//   in_valid    request present           in_ready   request can be taken
//   in_op       4-bit operation selector
//   in_rs/in_rt/in_rd/in_shamt  5-bit register / shift fields
//   in_imm      16-bit immediate / branch offset
//   in_target   26-bit J-type word target
//   out_valid   out_instr is a valid word  out_ready  consumer takes the word
//   out_instr   32-bit head-of-queue word
//   count       queue occupancy 0..4       err_illegal sticky illegal-op flag
// -----------------------------------------------------------------------------
interface instr_encoder_if;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [2:0]  count;
    logic        err_illegal;

    modport master (
        output clear, in_valid, in_op, in_rs, in_rt, in_rd, in_shamt,
               in_imm, in_target, out_ready,
        input  in_ready, out_valid, out_instr, count, err_illegal
    );

    modport slave (
        input  clear, in_valid, in_op, in_rs, in_rt, in_rd, in_shamt,
               in_imm, in_target, out_ready,
        output in_ready, out_valid, out_instr, count, err_illegal
    );
endinterface

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Encodes operation requests into 32-bit MIPS instruction words and queues
// them in a 4-entry FIFO for an instruction-memory writer.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    instr_encoder_if.slave (request fields, handshakes, status)
// Configuration:
//   FP_ENCODE_EN  when defined, op 15 encodes single-precision add.s;
//                 otherwise op 15 is illegal and raises err_illegal.
// -----------------------------------------------------------------------------
module instr_encoder (
    input  logic            clk,
    input  logic            rst_n,
    instr_encoder_if.slave  bus
);

    logic [31:0] mem [4];

    logic [1:0]  wr_ptr_reg, wr_ptr_next;
    logic [1:0]  rd_ptr_reg, rd_ptr_next;
    logic [2:0]  count_reg,  count_next;
    logic        err_reg,    err_next;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        req_fire;
    logic        push;
    logic        pop;

    // ---------------------------------------------------------------------
    // Encoder: pure function of the current request fields. Fields a format
    // does not use are replaced by zeros rather than passed through.
    // ---------------------------------------------------------------------
    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        case (bus.in_op)
            4'd0:  enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100000};
            4'd1:  enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100010};
            4'd2:  enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100100};
            4'd3:  enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100101};
            4'd4:  enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b101010};
            4'd5:  enc_word = {6'b000000, 5'd0, bus.in_rt, bus.in_rd, bus.in_shamt, 6'b000000};
            4'd6:  enc_word = {6'b000000, 5'd0, bus.in_rt, bus.in_rd, bus.in_shamt, 6'b000010};
            4'd7:  enc_word = {6'b000000, bus.in_rs, 15'd0, 6'b001000};
            4'd8:  enc_word = {6'b001000, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd9:  enc_word = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd10: enc_word = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd11: enc_word = {6'b000100, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd12: enc_word = {6'b000101, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd13: enc_word = {6'b000010, bus.in_target};
            4'd14: enc_word = {6'b000011, bus.in_target};
            default: begin
`ifdef FP_ENCODE_EN
                // add.s fd, fs, ft : COP1, fmt=S, ft=rt, fs=rd, fd=shamt
                enc_word = {6'b010001, 5'b10000, bus.in_rt, bus.in_rd, bus.in_shamt, 6'b000000};
`else
                enc_legal = 1'b0;
`endif
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Handshake and queue control. clear suppresses both push and pop so a
    // flush never half-applies a transfer.
    // ---------------------------------------------------------------------
    assign bus.in_ready  = (count_reg != 3'd4);
    assign bus.out_valid = (count_reg != 3'd0);
    assign bus.count     = count_reg;
    assign bus.err_illegal = err_reg;

    assign req_fire = bus.in_valid && bus.in_ready && !bus.clear;
    assign push     = req_fire && enc_legal;
    assign pop      = bus.out_valid && bus.out_ready && !bus.clear;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        err_next    = err_reg;
        if (bus.clear) begin
            wr_ptr_next = 2'd0;
            rd_ptr_next = 2'd0;
            count_next  = 3'd0;
            err_next    = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + 2'd1;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + 2'd1;
            end
            count_next = count_reg + {2'b00, push} - {2'b00, pop};
            if (req_fire && !enc_legal) begin
                err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 2'd0;
            rd_ptr_reg <= 2'd0;
            count_reg  <= 3'd0;
            err_reg    <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            err_reg    <= err_next;
        end
    end

    // Storage needs no reset: an entry is only visible while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= enc_word;
        end
    end

    // Gating by out_valid gives a zero word while empty or in reset.
    assign bus.out_instr = bus.out_valid ? mem[rd_ptr_reg] : 32'h0;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_encoder_if ifc ();

    instr_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int tests = 0;
    int fails = 0;
    logic [31:0] sb [$];
    bit err_m = 1'b0;

    // Reference encoder written from the opcode/funct table.
    function automatic void model(input logic [3:0] op, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic [4:0] rd,
                                  input logic [4:0] sh, input logic [15:0] imm,
                                  input logic [25:0] tg,
                                  output logic [31:0] w, output bit legal);
        legal = 1'b1;
        w = 32'h0;
        case (op)
            4'd0:  w = {6'h00, rs, rt, rd, 5'd0, 6'h20};
            4'd1:  w = {6'h00, rs, rt, rd, 5'd0, 6'h22};
            4'd2:  w = {6'h00, rs, rt, rd, 5'd0, 6'h24};
            4'd3:  w = {6'h00, rs, rt, rd, 5'd0, 6'h25};
            4'd4:  w = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
            4'd5:  w = {6'h00, 5'd0, rt, rd, sh, 6'h00};
            4'd6:  w = {6'h00, 5'd0, rt, rd, sh, 6'h02};
            4'd7:  w = {6'h00, rs, 5'd0, 5'd0, 5'd0, 6'h08};
            4'd8:  w = {6'h08, rs, rt, imm};
            4'd9:  w = {6'h23, rs, rt, imm};
            4'd10: w = {6'h2B, rs, rt, imm};
            4'd11: w = {6'h04, rs, rt, imm};
            4'd12: w = {6'h05, rs, rt, imm};
            4'd13: w = {6'h02, tg};
            4'd14: w = {6'h03, tg};
            default: begin
`ifdef FP_ENCODE_EN
                w = {6'h11, 5'h10, rt, rd, sh, 6'h00};
`else
                legal = 1'b0;
`endif
            end
        endcase
    endfunction

    task automatic drive(input logic v, input logic [3:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                         input logic [15:0] imm, input logic [25:0] tg);
        ifc.in_valid  = v;
        ifc.in_op     = op;
        ifc.in_rs     = rs;
        ifc.in_rt     = rt;
        ifc.in_rd     = rd;
        ifc.in_shamt  = sh;
        ifc.in_imm    = imm;
        ifc.in_target = tg;
    endtask

    // One clock: decide from the bench's own model what the edge should do,
    // advance to the next falling edge and update the scoreboard.
    task automatic cycle();
        bit acc, pop, lg;
        logic [31:0] w;
        acc = ifc.in_valid && (sb.size() < 4) && !ifc.clear;
        pop = (sb.size() != 0) && ifc.out_ready && !ifc.clear;
        model(ifc.in_op, ifc.in_rs, ifc.in_rt, ifc.in_rd, ifc.in_shamt,
              ifc.in_imm, ifc.in_target, w, lg);
        @(posedge clk);
        if (ifc.clear) begin
            sb.delete();
            err_m = 1'b0;
            $display("[TB] clear");
        end else begin
            if (pop) $display("[TB] pop  %h", sb.pop_front());
            if (acc && lg) begin
                sb.push_back(w);
                $display("[TB] push op %0d -> %h", ifc.in_op, w);
            end
            if (acc && !lg) begin
                err_m = 1'b1;
                $display("[TB] push op %0d rejected as illegal", ifc.in_op);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        tests++; if (ifc.count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", ifc.count); end
        tests++; if (ifc.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", ifc.out_valid); end
        tests++; if (ifc.out_instr !== 32'h0) begin fails++; $display("FAIL reset_out_instr: got %h want 0", ifc.out_instr); end
        tests++; if (ifc.err_illegal !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", ifc.err_illegal); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++; if (ifc.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", ifc.in_ready); end
    endtask

    task automatic test_single();
        ifc.out_ready = 1'b1;
        drive(1'b1, 4'd8, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0004, 26'h0);
        tests++; if (ifc.out_valid !== 1'b0) begin fails++; $display("FAIL single_no_comb_path: got %b want 0", ifc.out_valid); end
        cycle();
        idle();
        tests++; if (ifc.out_valid !== 1'b1) begin fails++; $display("FAIL single_out_valid: got %b want 1", ifc.out_valid); end
        tests++; if (ifc.out_instr !== 32'h20220004) begin fails++; $display("FAIL single_addi: got %h want 20220004", ifc.out_instr); end
        cycle();
        tests++; if (ifc.out_valid !== 1'b0) begin fails++; $display("FAIL single_drained: got %b want 0", ifc.out_valid); end
    endtask

    task automatic test_sequence();
        logic [31:0] exp3 [3];
        exp3[0] = 32'h00221820;
        exp3[1] = 32'h8C850008;
        exp3[2] = 32'h08000010;
        ifc.out_ready = 1'b0;
        drive(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        cycle();
        drive(1'b1, 4'd9, 5'd4, 5'd5, 5'd0, 5'd0, 16'h0008, 26'h0);
        cycle();
        drive(1'b1, 4'd13, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010);
        cycle();
        idle();
        tests++; if (ifc.count !== 3'd3) begin fails++; $display("FAIL seq_count: got %0d want 3", ifc.count); end
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests++; if (ifc.out_instr !== exp3[i]) begin fails++; $display("FAIL seq_word%0d: got %h want %h", i, ifc.out_instr, exp3[i]); end
            cycle();
        end
        tests++; if (ifc.count !== 3'd0) begin fails++; $display("FAIL seq_empty: got %0d want 0", ifc.count); end
    endtask

    task automatic test_full_wrap();
        logic [3:0] op;
        int n;
        ifc.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            op = 4'($urandom_range(0, 14));
            drive(1'b1, op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                  16'($urandom), 26'($urandom));
            if (i < 4) begin
                tests++; if (ifc.in_ready !== 1'b1) begin fails++; $display("FAIL full_ready%0d: got %b want 1", i, ifc.in_ready); end
                cycle();
            end
        end
        // Fifth request is presented against a full queue.
        tests++; if (ifc.count !== 3'd4) begin fails++; $display("FAIL full_count: got %0d want 4", ifc.count); end
        tests++; if (ifc.in_ready !== 1'b0) begin fails++; $display("FAIL full_not_ready: got %b want 0", ifc.in_ready); end
        cycle();
        tests++; if (ifc.count !== 3'd4) begin fails++; $display("FAIL full_held: got %0d want 4", ifc.count); end
        ifc.out_ready = 1'b1;
        tests++; if (ifc.in_ready !== 1'b0) begin fails++; $display("FAIL full_pop_no_push: got %b want 0", ifc.in_ready); end
        tests++; if (ifc.out_instr !== sb[0]) begin fails++; $display("FAIL full_head0: got %h want %h", ifc.out_instr, sb[0]); end
        cycle();
        tests++; if (ifc.count !== 3'd3) begin fails++; $display("FAIL full_after_pop: got %0d want 3", ifc.count); end
        tests++; if (ifc.out_instr !== sb[0]) begin fails++; $display("FAIL full_head1: got %h want %h", ifc.out_instr, sb[0]); end
        cycle();
        idle();
        tests++; if (ifc.count !== 3'd3) begin fails++; $display("FAIL full_push_pop: got %0d want 3", ifc.count); end
        n = 0;
        while (sb.size() != 0 && n < 8) begin
            tests++; if (ifc.out_instr !== sb[0]) begin fails++; $display("FAIL full_drain%0d: got %h want %h", n, ifc.out_instr, sb[0]); end
            cycle();
            n++;
        end
        tests++; if (ifc.out_valid !== 1'b0) begin fails++; $display("FAIL full_drained: got %b want 0", ifc.out_valid); end
    endtask

    task automatic test_jr_fp();
        ifc.out_ready = 1'b0;
        drive(1'b1, 4'd7, 5'd31, 5'd7, 5'd9, 5'd3, 16'h0, 26'h0);
        cycle();
        idle();
        tests++; if (ifc.out_instr !== 32'h03E00008) begin fails++; $display("FAIL jr_word: got %h want 03E00008", ifc.out_instr); end
        drive(1'b1, 4'd15, 5'd0, 5'd2, 5'd4, 5'd6, 16'h0, 26'h0);
        cycle();
        idle();
        cycle();
        tests++; if (ifc.err_illegal !== err_m) begin fails++; $display("FAIL op15_err: got %b want %b", ifc.err_illegal, err_m); end
        tests++; if (ifc.count !== 3'(sb.size())) begin fails++; $display("FAIL op15_count: got %0d want %0d", ifc.count, sb.size()); end
        ifc.out_ready = 1'b1;
        cycle();
`ifdef FP_ENCODE_EN
        tests++; if (ifc.out_instr !== 32'h46022180) begin fails++; $display("FAIL adds_word: got %h want 46022180", ifc.out_instr); end
`endif
        cycle();
        tests++; if (ifc.out_valid !== 1'b0) begin fails++; $display("FAIL jr_drained: got %b want 0", ifc.out_valid); end
    endtask

    task automatic test_clear();
        ifc.out_ready = 1'b0;
        drive(1'b1, 4'd3, 5'd8, 5'd9, 5'd10, 5'd0, 16'h0, 26'h0);
        cycle();
        drive(1'b1, 4'd11, 5'd8, 5'd9, 5'd0, 5'd0, 16'hFFFE, 26'h0);
        cycle();
        tests++; if (ifc.count !== 3'd2) begin fails++; $display("FAIL clr_pre_count: got %0d want 2", ifc.count); end
        ifc.clear = 1'b1;
        ifc.out_ready = 1'b1;
        drive(1'b1, 4'd8, 5'd1, 5'd1, 5'd0, 5'd0, 16'h1234, 26'h0);
        cycle();
        ifc.clear = 1'b0;
        idle();
        tests++; if (ifc.count !== 3'd0) begin fails++; $display("FAIL clr_count: got %0d want 0", ifc.count); end
        tests++; if (ifc.out_valid !== 1'b0) begin fails++; $display("FAIL clr_out_valid: got %b want 0", ifc.out_valid); end
        tests++; if (ifc.err_illegal !== 1'b0) begin fails++; $display("FAIL clr_err: got %b want 0", ifc.err_illegal); end
        cycle();
        tests++; if (ifc.count !== 3'd0) begin fails++; $display("FAIL clr_push_dropped: got %0d want 0", ifc.count); end
    endtask

    task automatic test_reset_mid();
        ifc.out_ready = 1'b0;
        drive(1'b1, 4'd1, 5'd5, 5'd6, 5'd7, 5'd0, 16'h0, 26'h0);
        cycle();
        drive(1'b1, 4'd14, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FFFFFF);
        cycle();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (ifc.count !== 3'd0) begin fails++; $display("FAIL rst_mid_count: got %0d want 0", ifc.count); end
        tests++; if (ifc.out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_out_valid: got %b want 0", ifc.out_valid); end
        tests++; if (ifc.out_instr !== 32'h0) begin fails++; $display("FAIL rst_mid_out_instr: got %h want 0", ifc.out_instr); end
        sb.delete();
        err_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ifc.out_ready = 1'b1;
        drive(1'b1, 4'd10, 5'd3, 5'd4, 5'd0, 5'd0, 16'h0055, 26'h0);
        cycle();
        idle();
        tests++; if (ifc.out_instr !== 32'hAC640055) begin fails++; $display("FAIL rst_mid_first: got %h want AC640055", ifc.out_instr); end
        cycle();
        tests++; if (ifc.out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_drained: got %b want 0", ifc.out_valid); end
    endtask

    initial begin
        ifc.clear = 1'b0;
        ifc.out_ready = 1'b0;
        idle();
        test_reset();
        test_single();
        test_sequence();
        test_full_wrap();
        test_jr_fp();
        test_clear();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
